// File: rtl/sdp_x_mul_core_chn_out_rsci_skid.sv
// ---------------------------------------------------------------------------
// sdp_x_mul_core_chn_out_rsci_skid
//
// Output-side ready/valid interface of the SDP X multiplier core. Each core
// push drops one result word into a DEPTH-entry skid FIFO; the head of the
// FIFO is presented downstream on chn_out_rsc_z / chn_out_rsc_lz and taken
// when chn_out_rsc_vz is high. Back-pressure goes back to the core stall
// logic through chn_out_rsci_bawt / chn_out_rsci_wen_comp.
//
// Handshake: a downstream transfer happens on a rising edge where lz=1 and
// vz=1. lz depends only on registered occupancy, is never retracted before a
// transfer, and z is held constant while lz=1 and vz=0.
//
// Parameters
//   WIDTH  data word width
//   DEPTH  skid entries, 1..4
//   RSCID  resource id, informational only
//
// Ports
//   nvdla_core_clk             core clock, rising edge
//   nvdla_core_rstn            asynchronous active-low reset
//   chn_out_rsc_z      [W]     head-of-FIFO data to downstream
//   chn_out_rsc_lz             downstream valid (FIFO non-empty)
//   chn_out_rsc_vz             downstream ready
//   core_wen                   core global enable
//   core_wten                  core was stalled last cycle
//   chn_out_rsci_oswt          current core state needs this channel
//   chn_out_rsci_iswt0         core issues a write this state
//   chn_out_rsci_ld_core_psct  core write strobe (pre-stall)
//   chn_out_rsci_d     [W]     core result word
//   chn_out_rsci_bawt          buffer can accept a word
//   chn_out_rsci_wen_comp      channel allows the core to advance
//   chn_out_rsci_cnt   [3]     FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sdp_x_mul_core_chn_out_rsci_skid #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 2,
    parameter int RSCID = 16
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    output logic [WIDTH-1:0] chn_out_rsc_z,
    output logic             chn_out_rsc_lz,
    input  logic             chn_out_rsc_vz,
    input  logic             core_wen,
    input  logic             core_wten,
    input  logic             chn_out_rsci_oswt,
    input  logic             chn_out_rsci_iswt0,
    input  logic             chn_out_rsci_ld_core_psct,
    input  logic [WIDTH-1:0] chn_out_rsci_d,
    output logic             chn_out_rsci_bawt,
    output logic             chn_out_rsci_wen_comp,
    output logic [2:0]       chn_out_rsci_cnt
);

    localparam int         PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_CNT = 3'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    generate
        if (DEPTH < 1 || DEPTH > 4 || RSCID < 0) begin : g_bad_param
            $error("sdp_x_mul_core_chn_out_rsci_skid: DEPTH must be 1..4, RSCID >= 0");
        end
    endgenerate

    logic [WIDTH-1:0] entry [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [2:0]       count;

    logic push_req;
    logic push;
    logic pop;
    logic not_full;

    // A push while the core was stalled last cycle is a replay of a word that
    // was already offered, so it is dropped to avoid duplicate entries.
    assign push_req = chn_out_rsci_ld_core_psct & chn_out_rsci_iswt0 &
                      core_wen & ~core_wten;

    // Acceptance is decided from the registered count only: a full buffer
    // refuses the push even if a pop frees a slot in the same cycle, which
    // keeps vz out of the core stall path.
    assign not_full = (count < DEPTH_CNT);
    assign push     = push_req & not_full;
    assign pop      = chn_out_rsc_lz & chn_out_rsc_vz;

    assign chn_out_rsc_lz        = (count != 3'd0);
    assign chn_out_rsc_z         = entry[rd_ptr];
    assign chn_out_rsci_bawt     = not_full;
    assign chn_out_rsci_wen_comp = ~chn_out_rsci_oswt | not_full;
    assign chn_out_rsci_cnt      = count;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            count  <= 3'd0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            if (push) begin
                entry[wr_ptr] <= chn_out_rsci_d;
                // Explicit wrap so non-power-of-2 depths cycle 0..DEPTH-1.
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + 3'(push) - 3'(pop);
        end
    end

endmodule

// File: tb/tb_sdp_x_mul_core_chn_out_rsci_skid.sv
// ---------------------------------------------------------------------------
// Bench for sdp_x_mul_core_chn_out_rsci_skid. Two instances (DEPTH=2 and
// DEPTH=3) share clock, reset and stimulus. Each has a reference occupancy
// and an expected-data queue; a monitor pops and compares whenever the DUT
// completes a downstream transfer.
// ---------------------------------------------------------------------------
module tb_sdp_x_mul_core_chn_out_rsci_skid;

    localparam int W = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         wen, wten, oswt, iswt0, ld, vz;
    logic [W-1:0] d;

    logic [W-1:0] z2, z3;
    logic         lz2, lz3, bawt2, bawt3, wc2, wc3;
    logic [2:0]   cnt2, cnt3;

    sdp_x_mul_core_chn_out_rsci_skid #(.WIDTH(W), .DEPTH(2), .RSCID(16)) dut2 (
        .nvdla_core_clk            (clk),
        .nvdla_core_rstn           (rst_n),
        .chn_out_rsc_z             (z2),
        .chn_out_rsc_lz            (lz2),
        .chn_out_rsc_vz            (vz),
        .core_wen                  (wen),
        .core_wten                 (wten),
        .chn_out_rsci_oswt         (oswt),
        .chn_out_rsci_iswt0        (iswt0),
        .chn_out_rsci_ld_core_psct (ld),
        .chn_out_rsci_d            (d),
        .chn_out_rsci_bawt         (bawt2),
        .chn_out_rsci_wen_comp     (wc2),
        .chn_out_rsci_cnt          (cnt2)
    );

    sdp_x_mul_core_chn_out_rsci_skid #(.WIDTH(W), .DEPTH(3), .RSCID(17)) dut3 (
        .nvdla_core_clk            (clk),
        .nvdla_core_rstn           (rst_n),
        .chn_out_rsc_z             (z3),
        .chn_out_rsc_lz            (lz3),
        .chn_out_rsc_vz            (vz),
        .core_wen                  (wen),
        .core_wten                 (wten),
        .chn_out_rsci_oswt         (oswt),
        .chn_out_rsci_iswt0        (iswt0),
        .chn_out_rsci_ld_core_psct (ld),
        .chn_out_rsci_d            (d),
        .chn_out_rsci_bawt         (bawt3),
        .chn_out_rsci_wen_comp     (wc3),
        .chn_out_rsci_cnt          (cnt3)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp2_q[$];
    logic [W-1:0] exp3_q[$];
    int ref2 = 0;
    int ref3 = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer completes at the next rising edge whenever lz & vz.
    always @(negedge clk) begin
        if (rst_n) begin
            if (lz2 && vz) begin
                if (exp2_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL z2_unexpected: got %0h expected no word", z2);
                end else begin
                    chk("z2_data", z2, exp2_q.pop_front());
                end
            end
            if (lz3 && vz) begin
                if (exp3_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL z3_unexpected: got %0h expected no word", z3);
                end else begin
                    chk("z3_data", z3, exp3_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus, entered and left at posedge+1. Status outputs
    // are checked at the falling edge against the reference occupancies.
    task automatic cycle(input bit ld_i, input bit iswt_i, input bit wen_i, input bit wten_i,
                         input bit oswt_i, input bit vz_i, input logic [W-1:0] d_i);
        bit req, push2, pop2, push3, pop3;
        ld = ld_i; iswt0 = iswt_i; wen = wen_i; wten = wten_i;
        oswt = oswt_i; vz = vz_i; d = d_i;
        @(negedge clk);
        req = ld_i & iswt_i & wen_i & ~wten_i;
        chk("cnt2", W'(cnt2), W'(ref2));
        chk("lz2", W'(lz2), W'(ref2 != 0));
        chk("bawt2", W'(bawt2), W'(ref2 < 2));
        chk("wen_comp2", W'(wc2), W'(!oswt_i || ref2 < 2));
        chk("cnt3", W'(cnt3), W'(ref3));
        chk("lz3", W'(lz3), W'(ref3 != 0));
        chk("bawt3", W'(bawt3), W'(ref3 < 3));
        chk("wen_comp3", W'(wc3), W'(!oswt_i || ref3 < 3));
        if (!vz_i && ref2 != 0 && exp2_q.size() != 0) chk("z2_hold", z2, exp2_q[0]);
        if (!vz_i && ref3 != 0 && exp3_q.size() != 0) chk("z3_hold", z3, exp3_q[0]);
        push2 = req && ref2 < 2;
        pop2  = vz_i && ref2 != 0;
        push3 = req && ref3 < 3;
        pop3  = vz_i && ref3 != 0;
        @(posedge clk);
        if (push2) exp2_q.push_back(d_i);
        if (push3) exp3_q.push_back(d_i);
        ref2 = ref2 + int'(push2) - int'(pop2);
        ref3 = ref3 + int'(push3) - int'(pop3);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d_i, input bit vz_i);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, vz_i, d_i);
    endtask

    task automatic idle(input bit vz_i);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, vz_i, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        wen = 1'b1; wten = 1'b0; oswt = 1'b1; iswt0 = 1'b0; ld = 1'b0; vz = 1'b0; d = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_cnt2", W'(cnt2), '0);
        chk("rst_lz2", W'(lz2), '0);
        chk("rst_z2", z2, '0);
        chk("rst_bawt2", W'(bawt2), W'(1));
        chk("rst_wc2", W'(wc2), W'(1));
        chk("rst_lz3", W'(lz3), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming with downstream always ready
        for (int i = 1; i <= 4; i++) push(W'(i), 1'b1);
        idle(1'b1);

        // Back-pressure: third word refused by the 2-deep instance
        push(W'('hA), 1'b0);
        push(W'('hB), 1'b0);
        push(W'('hC), 1'b0);
        idle(1'b0);
        repeat (4) idle(1'b1);

        // Full with push_req and pop together, then retry
        push(W'('h10), 1'b0);
        push(W'('h11), 1'b0);
        push(W'('h12), 1'b1);
        chk("full_pop_cnt2", W'(cnt2), W'(1));
        push(W'('h12), 1'b0);
        chk("retry_cnt2", W'(cnt2), W'(2));
        repeat (5) idle(1'b1);

        // Stall replay guard
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, W'('h55));
        chk("wten_cnt2", W'(cnt2), '0);
        idle(1'b0);

        // oswt=0 keeps wen_comp high while full; then hold with vz=0
        push(W'('h21), 1'b0);
        push(W'('h22), 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, W'('h77));
        repeat (10) idle(1'b0);

        // Asynchronous reset mid-stream with cnt2=2
        rst_n = 1'b0;
        #2;
        chk("arst_lz2", W'(lz2), '0);
        chk("arst_cnt2", W'(cnt2), '0);
        chk("arst_lz3", W'(lz3), '0);
        exp2_q.delete(); exp3_q.delete();
        ref2 = 0; ref3 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First word after reset is the next word out
        push(W'('h99), 1'b1);
        idle(1'b1);

        // Pointer wrap with random downstream readiness
        for (int i = 0; i < 7; i++) push(W'('h100 + i), 1'($urandom_range(0, 1)));
        repeat (6) idle(1'b1);

        chk("drain2", W'(exp2_q.size()), '0);
        chk("drain3", W'(exp3_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
